// File: rtl/msg_pkg.sv
// Shared definitions for the message assembler/disassembler pair.
// Words are ordered with word 0 in the least significant bits of a packet.
package msg_pkg;

  // Serialiser state; kept as plain vector constants for legacy tooling.
  typedef logic [0:0] state_t;
  localparam state_t SM_IDLE = 1'b0;
  localparam state_t SM_SEND = 1'b1;

  // Width in bits of one packet built from words_per_packet words.
  function automatic int packet_words(input int word_size, input int words_per_packet);
    return word_size * words_per_packet;
  endfunction

  // Bit offset of word idx inside a packet (word 0 sits in the LSBs).
  function automatic int word_lsb(input int word_size, input int idx);
    return word_size * idx;
  endfunction

endpackage

// File: rtl/msg_disasm.sv
// Message disassembler: pops one packet from the outbound FIFO and sends it
// word by word (word 0 first) to the UART transmitter.
module msg_disasm
  import msg_pkg::*;
#(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [WORD_SIZE-1:0]                 data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready,
  output logic                                 busy
);

  localparam int INPUT_WIDTH = packet_words(WORD_SIZE, WORDS_PER_PACKET);
  localparam int CTR_WIDTH   = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam int WORD0_LSB   = word_lsb(WORD_SIZE, 0);
  localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(WORDS_PER_PACKET - 1);

  state_t                 state_q, state_d;
  logic [CTR_WIDTH-1:0]   ctr_q, ctr_d;
  logic [INPUT_WIDTH-1:0] shreg_q, shreg_d;

  logic sending;
  logic word_accept;
  logic last_word;
  logic pop;

  // Handshake decode: a word leaves on valid&ready, a packet enters on pop.
  always_comb begin
    sending        = (state_q == SM_SEND);
    word_accept    = sending && data_out_ready;
    last_word      = (ctr_q == CTR_LAST);
    data_in_ready  = !reset && (!sending || (word_accept && last_word));
    pop            = data_in_ready && data_in_valid;
    data_out       = shreg_q[WORD0_LSB +: WORD_SIZE];
    data_out_valid = sending;
    busy           = sending;
  end

  // Next state: a pop always (re)enters SEND; finishing without a pop idles.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      state_d = SM_SEND;
    end else if (word_accept && last_word) begin
      state_d = SM_IDLE;
    end
  end

  // Next word index: restarts on a pop or packet end so it never passes the last word.
  always_comb begin
    ctr_d = ctr_q;
    if (pop || (word_accept && last_word)) begin
      ctr_d = '0;
    end else if (word_accept) begin
      ctr_d = ctr_q + CTR_WIDTH'(1);
    end
  end

  // Next shift register: load on pop, otherwise drop the sent word and zero-fill the top.
  always_comb begin
    shreg_d = shreg_q;
    if (pop) begin
      shreg_d = data_in;
    end else if (word_accept) begin
      shreg_d = shreg_q >> WORD_SIZE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SM_IDLE;
    else       state_q <= state_d;
  end

  // Word counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctr_q <= '0;
    else       ctr_q <= ctr_d;
  end

  // Shift register holding the words still to be sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_msg_disasm.sv
// Self-checking bench for msg_disasm: directed scenarios plus a randomized
// loopback checked by a behavioural reassembler model.
module tb_msg_disasm;

  logic        clk = 1'b0;
  logic        reset;

  // 4-word instance
  logic [31:0] d_in;
  logic        d_valid;
  logic        d_in_ready;
  logic [7:0]  d_out;
  logic        d_out_valid;
  logic        d_rdy;
  logic        d_busy;

  // 1-word instance
  logic [7:0]  s_in;
  logic        s_valid;
  logic        s_in_ready;
  logic [7:0]  s_out;
  logic        s_out_valid;
  logic        s_rdy;
  logic        s_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4)) u_dut (
    .clk(clk), .reset(reset),
    .data_in(d_in), .data_in_valid(d_valid), .data_in_ready(d_in_ready),
    .data_out(d_out), .data_out_valid(d_out_valid), .data_out_ready(d_rdy),
    .busy(d_busy)
  );

  msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .data_in(s_in), .data_in_valid(s_valid), .data_in_ready(s_in_ready),
    .data_out(s_out), .data_out_valid(s_out_valid), .data_out_ready(s_rdy),
    .busy(s_busy)
  );

  // Reference: byte idx of a packet, word 0 in the LSBs.
  function automatic logic [7:0] byte_of(input logic [31:0] pkt, input int idx);
    return 8'((pkt >> (8 * idx)) & 32'hFF);
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    d_in = '0; d_valid = 1'b0; d_rdy = 1'b0;
    s_in = '0; s_valid = 1'b0; s_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", d_out_valid); end
    n_vec++; if (d_out !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", d_out); end
    n_vec++; if (d_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", d_busy); end
    n_vec++; if (d_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", d_in_ready); end
    n_vec++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready1 got=%b exp=0", s_in_ready); end
    cyc;
    reset = 1'b0;
    // start a packet, send one word, then reset mid-packet
    d_in = 32'hCAFEF00D; d_valid = 1'b1; d_rdy = 1'b1;
    cyc;
    d_valid = 1'b0;
    cyc;
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", d_out_valid); end
    n_vec++; if (d_out !== 8'h00) begin n_err++; $display("FAIL midrst_data got=%h exp=00", d_out); end
    n_vec++; if (d_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", d_busy); end
    n_vec++; if (d_in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=0", d_in_ready); end
    cyc;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (d_in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready got=%b exp=1", d_in_ready); end
    n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL rel_no_resume got=%b exp=0", d_out_valid); end
    $display("reset: mid-packet reset and release done");
    cyc;
  endtask

  task automatic test_single;
    logic [31:0] pkt;
    pkt = 32'hDDCCBBAA;
    d_in = pkt; d_valid = 1'b1; d_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (d_in_ready !== 1'b1) begin n_err++; $display("FAIL single_pop_ready got=%b exp=1", d_in_ready); end
    cyc;
    d_valid = 1'b0;
    d_in = 32'h0BADBEEF;   // FIFO head changes after the pop must be ignored
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (d_out_valid !== 1'b1 || d_out !== byte_of(pkt, k)) begin
        n_err++; $display("FAIL single_word%0d got=%b/%h exp=1/%h", k, d_out_valid, d_out, byte_of(pkt, k));
      end
      $display("single: word %0d = %h", k, d_out);
      cyc;
    end
    @(negedge clk);
    n_vec++; if (d_out_valid !== 1'b0 || d_busy !== 1'b0 || d_in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_idle got valid=%b busy=%b rdy=%b exp=0/0/1", d_out_valid, d_busy, d_in_ready);
    end
    cyc;
  endtask

  task automatic test_back_to_back;
    logic [31:0] p1, p2;
    logic [7:0]  exp_w;
    logic        exp_r;
    p1 = 32'h04030201; p2 = 32'h08070605;
    d_in = p1; d_valid = 1'b1; d_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (d_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_pop1 got=%b exp=1", d_in_ready); end
    cyc;
    d_in = p2;
    for (int k = 1; k <= 8; k++) begin
      exp_w = (k <= 4) ? byte_of(p1, k - 1) : byte_of(p2, k - 5);
      exp_r = (k == 4) || (k == 8);
      @(negedge clk);
      n_vec++; if (d_out_valid !== 1'b1 || d_out !== exp_w) begin
        n_err++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", k, d_out_valid, d_out, exp_w);
      end
      n_vec++; if (d_in_ready !== exp_r) begin
        n_err++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, d_in_ready, exp_r);
      end
      $display("b2b: word %0d = %h", k, d_out);
      cyc;
      if (k == 4) d_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++; if (d_out_valid !== 1'b0 || d_busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got valid=%b busy=%b exp=0/0", d_out_valid, d_busy);
    end
    cyc;
  endtask

  task automatic test_stall;
    logic [31:0] pkt;
    int idx;
    pkt = 32'h11223344;
    d_in = pkt; d_valid = 1'b1; d_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (d_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_pop got=%b exp=1", d_in_ready); end
    cyc;
    d_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 200 && idx < 4; c++) begin
      d_rdy = 1'($urandom_range(0, 1));
      d_in = $urandom;
      @(negedge clk);
      // the current word must stay on the bus until accepted
      n_vec++; if (d_out_valid !== 1'b1 || d_out !== byte_of(pkt, idx)) begin
        n_err++; $display("FAIL stall_word%0d got=%b/%h exp=1/%h", idx, d_out_valid, d_out, byte_of(pkt, idx));
      end
      if (d_rdy) begin
        $display("stall: word %0d = %h accepted at cycle %0d", idx, d_out, c);
        idx++;
      end
      cyc;
    end
    n_vec++; if (idx != 4) begin n_err++; $display("FAIL stall_timeout got=%0d words exp=4", idx); end
    d_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle got=%b exp=0", d_out_valid); end
    cyc;
  endtask

  task automatic test_loopback;
    logic [31:0] fifo[$];
    logic [31:0] sent[$];
    logic [7:0]  words[$];
    logic [31:0] pkt, exp_p;
    logic        popped;
    int got;
    for (int i = 0; i < 100; i++) begin
      pkt = $urandom;
      fifo.push_back(pkt);
      sent.push_back(pkt);
    end
    got = 0;
    for (int c = 0; c < 6000 && got < 100; c++) begin
      d_valid = (fifo.size() > 0) && ($urandom_range(0, 3) != 0);
      d_in = d_valid ? fifo[0] : $urandom;
      d_rdy = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      popped = d_valid && d_in_ready;
      if (d_out_valid && d_rdy) begin
        words.push_back(d_out);
        if (words.size() == 4) begin
          pkt = '0;
          for (int i = 0; i < 4; i++) pkt |= 32'(words[i]) << (8 * i);
          words.delete();
          exp_p = sent.pop_front();
          n_vec++; if (pkt !== exp_p) begin
            n_err++; $display("FAIL loop_pkt%0d got=%h exp=%h", got, pkt, exp_p);
          end
          $display("loopback: packet %0d = %h", got, pkt);
          got++;
        end
      end
      cyc;
      if (popped) void'(fifo.pop_front());
    end
    n_vec++; if (got != 100) begin n_err++; $display("FAIL loop_timeout got=%0d packets exp=100", got); end
    d_valid = 1'b0; d_rdy = 1'b1;
    cyc;
  endtask

  task automatic test_wpp1;
    logic [7:0] w[2];
    w[0] = 8'h5A; w[1] = 8'hA5;
    s_in = w[0]; s_valid = 1'b1; s_rdy = 1'b1;
    @(negedge clk);
    n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL w1_pop0 got=%b exp=1", s_in_ready); end
    cyc;
    s_in = w[1];
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++; if (s_out_valid !== 1'b1 || s_out !== w[k]) begin
        n_err++; $display("FAIL w1_word%0d got=%b/%h exp=1/%h", k, s_out_valid, s_out, w[k]);
      end
      n_vec++; if (s_in_ready !== 1'b1) begin
        n_err++; $display("FAIL w1_ready%0d got=%b exp=1", k, s_in_ready);
      end
      $display("wpp1: word %0d = %h", k, s_out);
      cyc;
      if (k == 0) s_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++; if (s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL w1_idle got valid=%b busy=%b exp=0/0", s_out_valid, s_busy);
    end
    cyc;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_loopback;
    test_wpp1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
